ibex_compressed_encoder: RTL

//  Streaming RV32 compressor, inverse of the compressed decoder. Accepts 32-bit instructions, rewrites compressible ones to RVC form.

---
 rtl/ibex_cenc_pkg.sv | 24 ++
 rtl/ibex_compressed_encoder_core.sv | 99 +++++++++
 rtl/ibex_compressed_encoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ibex_cenc_pkg.sv
// Shared definitions for the RV32 -> RVC streaming compressor.
// Optional feature macro: CMP_ENC_STATS_EN (statistics counters, top level only).
package ibex_cenc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    localparam logic [15:0] C_NOP = 16'h0001;

    // One encoder result: a 16-bit item lives in data[15:0] with data[31:16] zero.
    typedef struct packed {
        logic [31:0] data;
        logic        is16;
    } enc_item_t;

    // True for the registers reachable through the 3-bit RVC register field (x8..x15).
    function automatic logic is_creg(input logic [4:0] r);
        return (r[4:3] == 2'b01);
    endfunction

endpackage

// File: rtl/ibex_compressed_encoder_core.sv
// Pure combinational RV32 -> RVC rewrite of a single instruction.
// Anything without a matching compressed form passes through unchanged.
module ibex_compressed_encoder_core
    import ibex_cenc_pkg::*;
#(
    parameter int ALLOW_LS = 1
) (
    input  logic [31:0] instr_i,
    output enc_item_t   item_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [20:0] imm_j;
    logic        imm_i_fits6;
    logic        imm_j_fits12;
    logic [15:0] c_instr;
    logic        is16;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = instr_i[31:20];
    assign imm_s  = {instr_i[31:25], instr_i[11:7]};
    assign imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // 6-bit signed immediate: the upper bits must all replicate bit 5.
    assign imm_i_fits6  = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
    // C.J reaches +-2 KiB: the upper bits must all replicate bit 11.
    assign imm_j_fits12 = (imm_j[20:11] == 10'h000) || (imm_j[20:11] == 10'h3ff);

    assign illegal_o = (instr_i[1:0] != 2'b11);

    // Pattern match each compressible form and build its 16-bit encoding.
    always_comb begin
        c_instr = 16'h0000;
        is16    = 1'b0;
        unique case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b000) begin
                    if ((rd == rs1) && (rd != 5'd0) && imm_i_fits6 && (imm_i != 12'h000)) begin
                        c_instr = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                        is16    = 1'b1;
                    end else if ((rd != 5'd0) && (rs1 == 5'd0) && imm_i_fits6) begin
                        c_instr = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                        is16    = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                if ((funct3 == 3'b000) && (funct7 == 7'h00) && (rd != 5'd0) && (rs2 != 5'd0)) begin
                    if (rs1 == 5'd0) begin
                        c_instr = {4'b1000, rd, rs2, 2'b10};
                        is16    = 1'b1;
                    end else if (rd == rs1) begin
                        c_instr = {4'b1001, rd, rs2, 2'b10};
                        is16    = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                if ((ALLOW_LS != 0) && (funct3 == 3'b010) && is_creg(rd) && is_creg(rs1) &&
                    (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00)) begin
                    c_instr = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                    is16    = 1'b1;
                end
            end
            OPC_STORE: begin
                if ((ALLOW_LS != 0) && (funct3 == 3'b010) && is_creg(rs2) && is_creg(rs1) &&
                    (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00)) begin
                    c_instr = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                    is16    = 1'b1;
                end
            end
            OPC_JAL: begin
                if ((rd == 5'd0) && imm_j_fits12) begin
                    c_instr = {3'b101, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6],
                               imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
                    is16    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign item_o.data = is16 ? {16'h0000, c_instr} : instr_i;
    assign item_o.is16 = is16;

endmodule

// File: rtl/ibex_compressed_encoder.sv
// Streaming RV32 compressor: one register stage of encoder results (S1)
// feeding a halfword packer that emits aligned 32-bit fetch words.
// Optional feature macro: CMP_ENC_STATS_EN adds n_cmp_o / n_full_o counters.
module ibex_compressed_encoder
    import ibex_cenc_pkg::*;
#(
    parameter int ALLOW_LS = 1,
    parameter int STAT_W   = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        flush_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        illegal_o,
    output logic        flush_done_o
`ifdef CMP_ENC_STATS_EN
    ,
    output logic [STAT_W-1:0] n_cmp_o,
    output logic [STAT_W-1:0] n_full_o
`endif
);

    enc_item_t   enc_item;
    logic        enc_illegal;

    logic        s1_valid;
    enc_item_t   s1_item;
    logic [15:0] hw_buf;
    logic        hw_valid;
    logic        flush_pend;

    logic        can_out;
    logic        s1_adv;
    logic        accept;
    logic        flush_fire;
    logic        word_new;
    logic [31:0] word_next;
    logic [15:0] hw_buf_next;
    logic        hw_valid_next;

    ibex_compressed_encoder_core #(
        .ALLOW_LS (ALLOW_LS)
    ) u_core (
        .instr_i   (instr_i),
        .item_o    (enc_item),
        .illegal_o (enc_illegal)
    );

    // Handshake: S1 may move only when the output register is free or being taken.
    always_comb begin
        can_out       = !word_valid_o || word_ready_i;
        s1_adv        = s1_valid && can_out;
        instr_ready_o = !s1_valid || s1_adv;
        accept        = instr_valid_i && instr_ready_o;
        // Flush waits for S1 to empty so the pad lands after every older item.
        flush_fire    = flush_pend && !s1_valid && can_out;
    end

    // Packer: combine the pending halfword with the S1 item, or pad it out on flush.
    always_comb begin
        word_new      = 1'b0;
        word_next     = word_o;
        hw_buf_next   = hw_buf;
        hw_valid_next = hw_valid;
        if (s1_adv) begin
            unique case ({hw_valid, s1_item.is16})
                2'b00: begin
                    word_new  = 1'b1;
                    word_next = s1_item.data;
                end
                2'b01: begin
                    hw_buf_next   = s1_item.data[15:0];
                    hw_valid_next = 1'b1;
                end
                2'b10: begin
                    // 32-bit item straddles the word boundary; its upper half stays pending.
                    word_new    = 1'b1;
                    word_next   = {s1_item.data[15:0], hw_buf};
                    hw_buf_next = s1_item.data[31:16];
                end
                default: begin
                    word_new      = 1'b1;
                    word_next     = {s1_item.data[15:0], hw_buf};
                    hw_valid_next = 1'b0;
                end
            endcase
        end else if (flush_fire && hw_valid) begin
            word_new      = 1'b1;
            word_next     = {C_NOP, hw_buf};
            hw_valid_next = 1'b0;
        end
    end

    // State registers: S1, packer, output word, flush control and status pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid     <= 1'b0;
            s1_item      <= '0;
            hw_buf       <= 16'h0000;
            hw_valid     <= 1'b0;
            flush_pend   <= 1'b0;
            word_o       <= 32'h0000_0000;
            word_valid_o <= 1'b0;
            illegal_o    <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            if (accept && !enc_illegal) begin
                s1_valid <= 1'b1;
                s1_item  <= enc_item;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            hw_buf       <= hw_buf_next;
            hw_valid     <= hw_valid_next;
            word_o       <= word_next;
            word_valid_o <= word_new || (word_valid_o && !word_ready_i);
            illegal_o    <= accept && enc_illegal;
            flush_done_o <= flush_fire;
            // A new request arriving as the old one completes re-arms the flush.
            flush_pend   <= flush_i || (flush_pend && !flush_fire);
        end
    end

`ifdef CMP_ENC_STATS_EN
    // Emitted-item statistics, counted when an item leaves S1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            n_cmp_o  <= '0;
            n_full_o <= '0;
        end else if (s1_adv) begin
            if (s1_item.is16) begin
                n_cmp_o <= n_cmp_o + 1'b1;
            end else begin
                n_full_o <= n_full_o + 1'b1;
            end
        end
    end
`else
    // STAT_W only sizes the statistics counters, which are absent in this build.
    if (STAT_W < 1) begin : g_stat_w_unused
    end
`endif

endmodule
